// File: rtl/vga_timing_pkg.sv
// Purpose: 640x480@60 VGA timing constants, shared types and small helpers.
// Latency: n/a (package only).
// Backpressure: n/a; the scan runs free at one pixel per clock.
// Contents: H/V visible, porch, sync and total constants, SCREEN_PIXELS,
//           position/address types, and visibility/sync/colour-bar functions.
package vga_timing_pkg;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FRONT   = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BACK    = 48;
  localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FRONT   = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BACK    = 33;
  localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam int unsigned SCREEN_PIXELS = 307200;
  localparam int unsigned FRAME_CYCLES  = H_TOTAL * V_TOTAL;
  localparam int unsigned BAR_WIDTH     = 80;

  typedef logic [9:0]  cnt_t;
  typedef logic [18:0] addr_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  function automatic logic is_visible(input cnt_t hc, input cnt_t vc);
    return (hc < cnt_t'(H_VISIBLE)) && (vc < cnt_t'(V_VISIBLE));
  endfunction

  // Active-low sync: low only inside the sync pulse window.
  function automatic logic hsync_n(input cnt_t hc);
    return !((hc >= cnt_t'(H_VISIBLE + H_FRONT)) &&
             (hc <  cnt_t'(H_VISIBLE + H_FRONT + H_SYNC)));
  endfunction

  function automatic logic vsync_n(input cnt_t vc);
    return !((vc >= cnt_t'(V_VISIBLE + V_FRONT)) &&
             (vc <  cnt_t'(V_VISIBLE + V_FRONT + V_SYNC)));
  endfunction

  function automatic addr_t pixel_addr(input cnt_t hc, input cnt_t vc);
    return addr_t'(vc) * addr_t'(H_VISIBLE) + addr_t'(hc);
  endfunction

  // Eight 80-pixel bars: white, yellow, cyan, green, magenta, red, blue, black.
  function automatic rgb_t bar_colour(input cnt_t hc);
    logic [2:0] bar;
    logic [2:0] on;
    bar = 3'(hc / cnt_t'(BAR_WIDTH));
    case (bar)
      3'd0:    on = 3'b111;
      3'd1:    on = 3'b110;
      3'd2:    on = 3'b011;
      3'd3:    on = 3'b010;
      3'd4:    on = 3'b101;
      3'd5:    on = 3'b100;
      3'd6:    on = 3'b001;
      default: on = 3'b000;
    endcase
    return '{r: {8{on[2]}}, g: {8{on[1]}}, b: {8{on[0]}}};
  endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Purpose: free-running hc/vc raster position counter with a programmable start offset.
// Latency: next-cycle position (oHcNext/oVcNext) is combinational from the held count.
// Backpressure: none; advances one position every clock.
// Ports: iClock, iReset (async active-low) -> oHcNext/oVcNext = position of the next cycle.
module vga_sync_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned START_OFFSET = 0
) (
  input  logic iClock,
  input  logic iReset,
  output cnt_t oHcNext,
  output cnt_t oVcNext
);

  // Start offset is a linear position inside one frame.
  localparam cnt_t START_H = cnt_t'(START_OFFSET % H_TOTAL);
  localparam cnt_t START_V = cnt_t'((START_OFFSET / H_TOTAL) % V_TOTAL);

  cnt_t hc_q, vc_q;
  cnt_t hc_d, vc_d;

  always_comb begin
    hc_d = hc_q + 10'd1;
    vc_d = vc_q;
    if (hc_q == cnt_t'(H_TOTAL - 1)) begin
      hc_d = '0;
      if (vc_q == cnt_t'(V_TOTAL - 1)) vc_d = '0;
      else                             vc_d = vc_q + 10'd1;
    end
  end

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      hc_q <= START_H;
      vc_q <= START_V;
    end else begin
      hc_q <= hc_d;
      vc_q <= vc_d;
    end
  end

  assign oHcNext = hc_d;
  assign oVcNext = vc_d;

endmodule

// File: rtl/vga_scan_controller.sv
// Purpose: VGA 640x480 scan controller; fetches pixels by linear address and drives DAC + syncs.
// Latency: oAddress leads its driven pixel by PIXEL_LATENCY+1 cycles; all outputs registered.
// Backpressure: none; the renderer must return iPixel exactly PIXEL_LATENCY cycles after oAddress.
// Ports: iClock, iReset (async active-low), iPixel[23:0] RGB888 in, oAddress[18:0] fetch address,
//        oR/oG/oB colour, oHSync/oVSync active-low, oBlankN visible flag, oFrameStart at (0,0).
// Option: VGA_SCAN_TEST_PATTERN_EN adds iTestPattern, replacing visible colour with 8 colour bars.
module vga_scan_controller
  import vga_timing_pkg::*;
#(
  parameter int unsigned PIXEL_LATENCY = 2
) (
  input  logic        iClock,
  input  logic        iReset,
`ifdef VGA_SCAN_TEST_PATTERN_EN
  input  logic        iTestPattern,
`endif
  input  logic [23:0] iPixel,
  output logic [18:0] oAddress,
  output logic [7:0]  oR,
  output logic [7:0]  oG,
  output logic [7:0]  oB,
  output logic        oHSync,
  output logic        oVSync,
  output logic        oBlankN,
  output logic        oFrameStart
);

  // Scanning resumes at the first vertical-blank line, so no partial visible
  // pixel follows a reset. The fetch counter runs PIXEL_LATENCY+1 positions ahead.
  localparam int unsigned DISP_START  = V_VISIBLE * H_TOTAL;
  localparam int unsigned FETCH_START = (DISP_START + PIXEL_LATENCY + 1) % FRAME_CYCLES;

  cnt_t disp_hc_d, disp_vc_d;
  cnt_t fetch_hc_d, fetch_vc_d;

  vga_sync_counter #(.START_OFFSET(DISP_START)) u_disp_cnt (
    .iClock  (iClock),
    .iReset  (iReset),
    .oHcNext (disp_hc_d),
    .oVcNext (disp_vc_d)
  );

  vga_sync_counter #(.START_OFFSET(FETCH_START)) u_fetch_cnt (
    .iClock  (iClock),
    .iReset  (iReset),
    .oHcNext (fetch_hc_d),
    .oVcNext (fetch_vc_d)
  );

  addr_t addr_q, addr_d;
  rgb_t  rgb_q, rgb_d;
  rgb_t  pix_colour;
  logic  disp_vis_d;
  logic  hsync_q, vsync_q, blank_n_q, frame_start_q;

  // Output registers are loaded from the position of the coming cycle, so the
  // registered outputs describe the position of the cycle they appear in.
  // iPixel present now belongs to the address issued PIXEL_LATENCY cycles ago,
  // which is exactly the pixel displayed next cycle.
  always_comb begin
    disp_vis_d = is_visible(disp_hc_d, disp_vc_d);
    pix_colour = rgb_t'(iPixel);
`ifdef VGA_SCAN_TEST_PATTERN_EN
    if (iTestPattern) pix_colour = bar_colour(disp_hc_d);
`endif
    rgb_d = disp_vis_d ? pix_colour : '0;

    // Address only moves during fetch cycles; otherwise it holds.
    addr_d = addr_q;
    if (is_visible(fetch_hc_d, fetch_vc_d)) addr_d = pixel_addr(fetch_hc_d, fetch_vc_d);
  end

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      addr_q        <= addr_t'(SCREEN_PIXELS - 1);
      rgb_q         <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      blank_n_q     <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      addr_q        <= addr_d;
      rgb_q         <= rgb_d;
      hsync_q       <= hsync_n(disp_hc_d);
      vsync_q       <= vsync_n(disp_vc_d);
      blank_n_q     <= disp_vis_d;
      frame_start_q <= (disp_hc_d == '0) && (disp_vc_d == '0);
    end
  end

  assign oAddress    = addr_q;
  assign oR          = rgb_q.r;
  assign oG          = rgb_q.g;
  assign oB          = rgb_q.b;
  assign oHSync      = hsync_q;
  assign oVSync      = vsync_q;
  assign oBlankN     = blank_n_q;
  assign oFrameStart = frame_start_q;

endmodule

// File: tb/tb_vga_scan_controller.sv
// Purpose: scoreboard bench for vga_scan_controller against a linear-position raster model.
// Latency: expected outputs are queued per cycle and popped by a negedge monitor.
// Backpressure: none; a model renderer answers every address after PIXEL_LATENCY cycles.
module tb_vga_scan_controller;

  localparam int LAT        = 2;
  localparam int HT         = 800;
  localparam int FRAME      = 420000;
  localparam int RESET_POS  = 480 * HT;
  localparam int STAT_WIN   = 36800;

  logic        iClock;
  logic        iReset;
  logic [23:0] iPixel;
  logic [18:0] oAddress;
  logic [7:0]  oR, oG, oB;
  logic        oHSync, oVSync, oBlankN, oFrameStart;
`ifdef VGA_SCAN_TEST_PATTERN_EN
  logic        iTestPattern;
`endif

  vga_scan_controller #(.PIXEL_LATENCY(LAT)) dut (
    .iClock      (iClock),
    .iReset      (iReset),
`ifdef VGA_SCAN_TEST_PATTERN_EN
    .iTestPattern(iTestPattern),
`endif
    .iPixel      (iPixel),
    .oAddress    (oAddress),
    .oR          (oR),
    .oG          (oG),
    .oB          (oB),
    .oHSync      (oHSync),
    .oVSync      (oVSync),
    .oBlankN     (oBlankN),
    .oFrameStart (oFrameStart)
  );

  typedef struct packed {
    logic [18:0] addr;
    logic [23:0] rgb;
    logic        hs, vs, bn, fs;
  } obs_t;

  typedef struct {
    obs_t exp;
    int   ph;
    int   k;
  } item_t;

  item_t sb_q[$];
  int    errors = 0;
  int    checks = 0;
  int    exp_addr;
  logic [23:0] key;
  bit    tp;
  int    hs_low[2], vs_low[2], bn_hi[2], a0_cnt[2], fs_cnt[2];
  int    first_a0[2], first_fs[2], hold_cnt[2];

  initial iClock = 1'b0;
  always #20 iClock = ~iClock;

  // ---- reference model: raster position as a plain linear index ----
  function automatic int pos_of(input int k);
    return (RESET_POS + k) % FRAME;
  endfunction

  function automatic bit vis(input int p);
    return ((p % HT) < 640) && ((p / HT) < 480);
  endfunction

  function automatic int lin(input int p);
    return (p / HT) * 640 + (p % HT);
  endfunction

  function automatic logic [23:0] render(input int a);
    return 24'(a) ^ key;
  endfunction

  function automatic logic [23:0] bar_rgb(input int x);
    case (x / 80)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic obs_t reset_obs();
    obs_t o;
    o.addr = 19'd307199;
    o.rgb  = '0;
    o.hs   = 1'b1;
    o.vs   = 1'b1;
    o.bn   = 1'b0;
    o.fs   = 1'b0;
    return o;
  endfunction

  // Expected outputs for cycle k after reset release (updates held address).
  function automatic obs_t model_obs(input int k);
    obs_t o;
    int   p, q, x, y;
    p = pos_of(k);
    q = pos_of(k + LAT + 1);
    if (vis(q)) exp_addr = lin(q);
    x = p % HT;
    y = p / HT;
    o.addr = 19'(exp_addr);
    o.hs   = !(x >= 656 && x < 752);
    o.vs   = !(y >= 490 && y < 492);
    o.bn   = vis(p);
    o.fs   = (p == 0);
    if (!vis(p))  o.rgb = '0;
    else if (tp)  o.rgb = bar_rgb(x);
    else          o.rgb = render(lin(p));
    return o;
  endfunction

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // ---- monitor: pop one expectation per cycle and compare ----
  always @(negedge iClock) begin
    item_t it;
    obs_t  act;
    if (sb_q.size() > 0) begin
      it  = sb_q.pop_front();
      act = {oAddress, oR, oG, oB, oHSync, oVSync, oBlankN, oFrameStart};
      checks++;
      if (act !== it.exp) begin
        errors++;
        $display("FAIL scan ph=%0d k=%0d got addr=%0d rgb=%h hs=%b vs=%b bn=%b fs=%b want addr=%0d rgb=%h hs=%b vs=%b bn=%b fs=%b",
                 it.ph, it.k, act.addr, act.rgb, act.hs, act.vs, act.bn, act.fs,
                 it.exp.addr, it.exp.rgb, it.exp.hs, it.exp.vs, it.exp.bn, it.exp.fs);
      end
      if (it.ph >= 0 && it.k < STAT_WIN) begin
        if (!oHSync)  hs_low[it.ph]++;
        if (!oVSync)  vs_low[it.ph]++;
        if (oBlankN)  bn_hi[it.ph]++;
        if (oAddress == 19'd0) begin
          a0_cnt[it.ph]++;
          if (first_a0[it.ph] < 0) first_a0[it.ph] = it.k;
        end
        if (oFrameStart) begin
          fs_cnt[it.ph]++;
          if (first_fs[it.ph] < 0) first_fs[it.ph] = it.k;
        end
        if (it.k < 35997 && oAddress == 19'd307199) hold_cnt[it.ph]++;
      end
    end
  end

  // ---- stimulus: release reset, run, act as renderer, queue expectations ----
  task automatic run_phase(input int ph, input int ncyc, input bit end_with_reset);
    int a0, a1, a2;
    obs_t act;
    a0 = 307199; a1 = a0; a2 = a0;
    exp_addr = 307199;
    for (int k = 0; k <= ncyc && errors <= 200; k++) begin
      @(posedge iClock); #1;
      if (k == 0) iReset = 1'b1;
      a2 = a1; a1 = a0; a0 = int'(oAddress);
      // Renderer answers the address from LAT cycles ago; data that lands on a
      // blanked position is random junk that must never reach the DAC.
      if (vis(pos_of(k + 1))) iPixel = render(a2);
      else                    iPixel = 24'($urandom);
      if (end_with_reset && k == ncyc) begin
        #2 iReset = 1'b0;
        #1;
        act = {oAddress, oR, oG, oB, oHSync, oVSync, oBlankN, oFrameStart};
        checks++;
        if (act !== reset_obs()) begin
          errors++;
          $display("FAIL async_reset got=%h want=%h", act, reset_obs());
        end
        sb_q.push_back('{reset_obs(), -1, k});
      end else begin
        sb_q.push_back('{model_obs(k), ph, k});
      end
    end
  endtask

  initial begin
    iReset = 1'b0;
    iPixel = '0;
    key    = '0;
    tp     = 1'b0;
`ifdef VGA_SCAN_TEST_PATTERN_EN
    iTestPattern = 1'b0;
`endif
    for (int i = 0; i < 2; i++) begin
      first_a0[i] = -1;
      first_fs[i] = -1;
      hs_low[i] = 0; vs_low[i] = 0; bn_hi[i] = 0;
      a0_cnt[i] = 0; fs_cnt[i] = 0; hold_cnt[i] = 0;
    end
    repeat (5) begin
      @(posedge iClock); #1;
      iPixel = 24'($urandom);
      sb_q.push_back('{reset_obs(), -1, 0});
    end

    // Phase 0: identity renderer, reset asserted mid-frame at (300,5).
    run_phase(0, 36000 + 5 * HT + 300, 1'b1);
    repeat (4) begin
      @(posedge iClock); #1;
      iPixel = 24'($urandom);
      sb_q.push_back('{reset_obs(), -1, 0});
    end

    // Phase 1: random colour key (or colour bars when the option exists).
    key = 24'($urandom);
`ifdef VGA_SCAN_TEST_PATTERN_EN
    tp = 1'b1;
    iTestPattern = 1'b1;
`endif
    run_phase(1, 36000 + 3 * HT + 100, 1'b0);
    @(negedge iClock); #1;

    for (int p = 0; p < 2; p++) begin
      check_int($sformatf("hsync_low_cycles_ph%0d", p), hs_low[p], 46 * 96);
      check_int($sformatf("vsync_low_cycles_ph%0d", p), vs_low[p], 1600);
      check_int($sformatf("blank_high_first_line_ph%0d", p), bn_hi[p], 640);
      check_int($sformatf("addr0_count_ph%0d", p), a0_cnt[p], 1);
      check_int($sformatf("addr0_first_cycle_ph%0d", p), first_a0[p], 35997);
      check_int($sformatf("frame_start_count_ph%0d", p), fs_cnt[p], 1);
      check_int($sformatf("frame_start_cycle_ph%0d", p), first_fs[p], 36000);
      check_int($sformatf("addr_hold_vblank_ph%0d", p), hold_cnt[p], 35997);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
